// File: rtl/dsp_mac_scheduler.sv
// Round-robin issue of operand sets into one shared MAC slice; results return LAT+2 cycles after grant.
// Grants are withheld when FIFO entries plus in-flight issues reach FIFO_DEPTH, so captures never overrun.
module dsp_mac_scheduler #(
  parameter int  N_REQ      = 4,
  parameter int  LAT        = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*18-1:0]  req_a,
  input  logic [N_REQ*18-1:0]  req_b,
  input  logic [N_REQ*18-1:0]  req_d,
  input  logic [N_REQ*48-1:0]  req_c,
  output logic [N_REQ-1:0]     gnt,
  output logic [17:0]          dsp_a,
  output logic [17:0]          dsp_b,
  output logic [17:0]          dsp_d,
  output logic [47:0]          dsp_c,
  input  logic [47:0]          dsp_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [47:0]          rsp_data,
  output logic                 busy
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [IDW-1:0] rr_q, rr_d, win;
  logic [IDW:0]   cand;
  logic           found, any_req, can_issue, issue;
  logic [CW:0]    used;

  logic [17:0]    a_q, a_d, b_q, b_d, d_q, d_d;
  logic [47:0]    c_q, c_d;

  logic [LAT:0]   vld_q;
  logic [IDW-1:0] tid_q [LAT+1];
  logic           push, pop;

  logic [IDW-1:0] mem_id  [FIFO_DEPTH];
  logic [47:0]    mem_dat [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d, inflight_q, inflight_d;

  // Rotating search: first asserted requester at or after rr_q, wrapping mod N_REQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  assign any_req   = |req;
  assign used      = {1'b0, count_q} + {1'b0, inflight_q};
  assign can_issue = (used < DEPTH_W);
  assign issue     = any_req && can_issue;

  always_comb begin
    gnt = '0;
    if (issue) gnt[win] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (issue) rr_d = (win == LAST_ID) ? '0 : win + 1'b1;
  end

  always_comb begin
    a_d = '0;
    b_d = '0;
    d_d = '0;
    c_d = '0;
    if (issue) begin
      a_d = req_a[win*18 +: 18];
      b_d = req_b[win*18 +: 18];
      d_d = req_d[win*18 +: 18];
      c_d = req_c[win*48 +: 48];
    end
  end

  assign push      = vld_q[LAT];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + 1'b1;
    else if (!issue && push) inflight_d = inflight_q - 1'b1;
  end

  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop  ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
      c_q        <= '0;
      vld_q      <= '0;
      for (int k = 0; k <= LAT; k++) tid_q[k] <= '0;
      inflight_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      d_q        <= d_d;
      c_q        <= c_d;
      vld_q      <= {vld_q[LAT-1:0], issue};
      tid_q[0]   <= issue ? win : '0;
      for (int k = 1; k <= LAT; k++) tid_q[k] <= tid_q[k-1];
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
    end
  end

  // When full, a same-edge push lands in the slot the consumer is popping this cycle.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_id[wr_q]  <= tid_q[LAT];
      mem_dat[wr_q] <= dsp_p;
    end
  end

  assign dsp_a    = a_q;
  assign dsp_b    = b_q;
  assign dsp_d    = d_q;
  assign dsp_c    = c_q;
  assign rsp_id   = rsp_valid ? mem_id[rd_q]  : '0;
  assign rsp_data = rsp_valid ? mem_dat[rd_q] : '0;
  assign busy     = (inflight_q != '0) || rsp_valid;

endmodule

// File: tb/tb_dsp_mac_scheduler.sv
// Directed bench for dsp_mac_scheduler with a behavioural LAT-stage (D+B)*A+C slice and response scoreboard.
module tb_dsp_mac_scheduler;

  localparam int N_REQ      = 4;
  localparam int LAT        = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = 2;

  logic                CLK = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*18-1:0] req_a, req_b, req_d;
  logic [N_REQ*48-1:0] req_c;
  logic [N_REQ-1:0]    gnt;
  logic [17:0]         dsp_a, dsp_b, dsp_d;
  logic [47:0]         dsp_c, dsp_p;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [47:0]         rsp_data;
  logic                busy;

  logic [17:0] opa [N_REQ];
  logic [17:0] opb [N_REQ];
  logic [17:0] opd [N_REQ];
  logic [47:0] opc [N_REQ];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [47:0]    dat;
  } rsp_t;
  rsp_t sb_q[$];

  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;
  int   wait_n;
  logic stale;

  dsp_mac_scheduler #(.N_REQ(N_REQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK(CLK), .rst(rst), .req(req),
    .req_a(req_a), .req_b(req_b), .req_d(req_d), .req_c(req_c),
    .gnt(gnt),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    req_a = '0;
    req_b = '0;
    req_d = '0;
    req_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*18 +: 18] = opa[i];
      req_b[i*18 +: 18] = opb[i];
      req_d[i*18 +: 18] = opd[i];
      req_c[i*48 +: 48] = opc[i];
    end
  end

  function automatic logic [47:0] mac(input logic [17:0] a, input logic [17:0] b,
                                      input logic [17:0] d, input logic [47:0] c);
    logic [47:0] s;
    s = 48'(d) + 48'(b);
    return s * 48'(a) + c;
  endfunction

  logic [47:0] p_pipe [LAT];
  always @(posedge CLK) begin
    p_pipe[0] <= mac(dsp_a, dsp_b, dsp_d, dsp_c);
    for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign dsp_p = p_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int id);
    logic [N_REQ-1:0] e;
    rsp_t r;
    e = '0;
    e[id] = 1'b1;
    check(tag, 64'(gnt), 64'(e));
    r.id  = IDW'(id);
    r.dat = mac(opa[id], opb[id], opd[id], opc[id]);
    sb_q.push_back(r);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((busy || sb_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  // Consumer side: every pop is matched against the scoreboard in grant order.
  always @(negedge CLK) begin
    rsp_t r;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        r = sb_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(r.id));
        check("rsp_data", 64'(rsp_data), 64'(r.dat));
      end
    end
    n_assert++;
    assert (!(dut.push && (int'(dut.count_q) == FIFO_DEPTH) && !(rsp_valid && rsp_ready))) else begin
      n_fail++;
      $error("FAIL fifo_overflow: observed push into full fifo without pop, expected none");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      opd[i] = '0;
      opc[i] = '0;
    end
    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dsp_a", 64'(dsp_a), 64'd0);
    check("rst_dsp_b", 64'(dsp_b), 64'd0);
    check("rst_dsp_d", 64'(dsp_d), 64'd0);
    check("rst_dsp_c", 64'(dsp_c), 64'd0);
    rst = 1'b0;

    // Single request: (5+2)*3+10 = 31
    tick();
    opa[0] = 18'd3; opb[0] = 18'd2; opd[0] = 18'd5; opc[0] = 48'd10;
    req = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check("t1_gnt", 64'(gnt), 64'b0001);
    sb_q.push_back('{id: 2'd0, dat: 48'd31});
    tick();
    req = '0;
    #1;
    check("t1_dsp_a", 64'(dsp_a), 64'd3);
    check("t1_dsp_b", 64'(dsp_b), 64'd2);
    check("t1_dsp_d", 64'(dsp_d), 64'd5);
    check("t1_dsp_c", 64'(dsp_c), 64'd10);
    check("t1_busy", 64'(busy), 64'd1);
    lat = 1;
    tick();
    lat = 2;
    check("t1_dsp_a_clr", 64'(dsp_a), 64'd0);
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(LAT + 2));
    check("t1_rsp_id", 64'(rsp_id), 64'd0);
    check("t1_rsp_data", 64'(rsp_data), 64'd31);
    tick();
    check("t1_busy_idle", 64'(busy), 64'd0);

    // Round-robin from a freshly reset pointer
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      opa[i] = 18'(10 + i);
      opb[i] = 18'(i + 1);
      opd[i] = 18'(2 * i);
      opc[i] = 48'(1000 * i);
    end
    req = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      #1;
      wait_n = 0;
      while (gnt == '0 && wait_n < 10) begin
        tick();
        #1;
        wait_n++;
      end
      expect_grant("t2_gnt", g % N_REQ);
      tick();
    end
    req = '0;
    wait_idle("t2");

    // Credit stall with the consumer stopped; operands change after every grant
    rsp_ready = 1'b0;
    opa[1] = 18'd7; opd[1] = 18'd1; opc[1] = 48'd5; opb[1] = 18'd100;
    req = 4'b0010;
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      #1;
      expect_grant("t3_gnt", 1);
      tick();
      opb[1] = opb[1] + 18'd1;
    end
    for (int c = 0; c < 8; c++) begin
      #1;
      check("t3_stall", 64'(gnt), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_full_gnt", 64'(gnt), 64'd0);
    check("t3_full_cnt", 64'(dut.count_q), 64'd4);
    tick();
    rsp_ready = 1'b0;
    #1;
    expect_grant("t3_regrant", 1);
    tick();
    opb[1] = opb[1] + 18'd1;
    #1;
    check("t3_stall2", 64'(gnt), 64'd0);

    // Capture of the regranted item coincides with a pop: count must hold at 3
    tick();
    req = '0;
    repeat (3) tick();
    rsp_ready = 1'b1;
    #1;
    check("t4_cnt_before", 64'(dut.count_q), 64'd3);
    check("t4_inflight_before", 64'(dut.inflight_q), 64'd1);
    check("t4_capture", 64'(dut.push), 64'd1);
    tick();
    rsp_ready = 1'b0;
    #1;
    check("t4_cnt_after", 64'(dut.count_q), 64'd3);
    check("t4_inflight_after", 64'(dut.inflight_q), 64'd0);
    wait_idle("t4");

    // Reset with two results queued and two in flight
    rsp_ready = 1'b0;
    opb[1] = 18'd200;
    req = 4'b0010;
    #1;
    expect_grant("t5_gnt", 1);
    tick();
    opb[1] = 18'd201;
    #1;
    expect_grant("t5_gnt", 1);
    tick();
    req = '0;
    repeat (5) tick();
    opb[1] = 18'd202;
    req = 4'b0010;
    #1;
    expect_grant("t5_gnt", 1);
    tick();
    opb[1] = 18'd203;
    #1;
    expect_grant("t5_gnt", 1);
    tick();
    req = '0;
    #1;
    check("t5_pre_dsp_b", 64'(dsp_b), 64'd203);
    check("t5_pre_cnt", 64'(dut.count_q), 64'd2);
    check("t5_pre_inflight", 64'(dut.inflight_q), 64'd2);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("t5_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_dsp_a", 64'(dsp_a), 64'd0);
    check("t5_rst_dsp_b", 64'(dsp_b), 64'd0);
    check("t5_rst_dsp_d", 64'(dsp_d), 64'd0);
    check("t5_rst_dsp_c", 64'(dsp_c), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      tick();
      stale = stale | rsp_valid | busy;
    end
    check("t5_no_stale", 64'(stale), 64'd0);
    req = 4'b1111;
    #1;
    expect_grant("t5_after_rst", 0);
    tick();
    req = '0;
    wait_idle("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
